// File: rtl/ram_ctrl_seq_pkg.sv
// Shared types and constants for the ram_ctrl_seq memory-access sequencer.
package ram_ctrl_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [7:0] DEF_RD_T4_MSK = 8'b0100_0111;
  localparam logic [7:0] DEF_WR_T4_MSK = 8'b0010_1000;
  localparam logic [7:0] DEF_WR_T6_MSK = 8'b0100_0000;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ram_ctrl_seq_if.sv
// Bus between the control unit / RAM side and the ram_ctrl_seq sequencer.
interface ram_ctrl_seq_if import ram_ctrl_seq_pkg::*; #(
  parameter int NUM_T  = 8,
  parameter int NUM_OP = 8
) ();

  // Handshake: LD or WR is a one-cycle request strobe; MEM_RDY is the memory's
  // completion and is only accepted once the wait counter has reached WAIT_CYC.
  logic              START;
  logic              CLR_SC;
  logic [NUM_OP-1:0] D;
  logic              I;
  logic              MEM_RDY;
  logic [NUM_T-1:0]  T;
  logic              LD;
  logic              WR;
  logic              BUSY;
  logic              ERR;
  state_t            state;

  modport master (
    output START, CLR_SC, D, I, MEM_RDY,
    input  T, LD, WR, BUSY, ERR, state
  );

  modport slave (
    input  START, CLR_SC, D, I, MEM_RDY,
    output T, LD, WR, BUSY, ERR, state
  );

endinterface

// File: rtl/ram_ctrl_seq_sc_ring.sv
// One-hot sequence counter ring: rotates left, holds on hold, returns to T0 on clr.
module sc_ring #(
  parameter int NUM_T = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hold,
  input  logic             clr,
  output logic [NUM_T-1:0] t
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      t <= NUM_T'(1);
    end else if (clr) begin
      t <= NUM_T'(1);
    end else if (!hold) begin
      t <= {t[NUM_T-2:0], t[NUM_T-1]};
    end
  end

endmodule

// File: rtl/ram_ctrl_seq.sv
// Memory-access sequencer: owns T0..T(N-1), issues LD/WR strobes, stalls T until MEM_RDY.
// Optional access timeout enabled by defining ACCESS_TIMEOUT_EN.
module ram_ctrl_seq import ram_ctrl_seq_pkg::*; #(
  parameter int NUM_T    = 8,
  parameter int NUM_OP   = 8,
  parameter int WAIT_CYC = 1,
`ifdef ACCESS_TIMEOUT_EN
  parameter int TIMEOUT  = 15,
`endif
  parameter logic [NUM_OP-1:0] RD_T4_MSK = DEF_RD_T4_MSK,
  parameter logic [NUM_OP-1:0] WR_T4_MSK = DEF_WR_T4_MSK,
  parameter logic [NUM_OP-1:0] WR_T6_MSK = DEF_WR_T6_MSK
) (
  input  logic         CLK,
  input  logic         RSTN,
  ram_ctrl_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_CYC);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             clr_pend;
  logic             ld_q;
  logic             wr_q;
  logic             ld_nx;
  logic             wr_nx;
  logic             rd_req;
  logic             wr_req;
  logic             any_req;
  logic             done;
  logic             tmo;
  logic             ring_hold;
  logic             ring_clr;
  logic [NUM_T-1:0] t;

  assign rd_req  = t[1] | (t[3] & ~bus.D[NUM_OP-1] & bus.I) | (t[4] & |(bus.D & RD_T4_MSK));
  assign wr_req  = (t[4] & |(bus.D & WR_T4_MSK)) | (t[6] & |(bus.D & WR_T6_MSK));
  assign any_req = rd_req | wr_req;
  assign done    = bus.MEM_RDY & (cnt >= WAIT_LIM);

`ifdef ACCESS_TIMEOUT_EN
  // Last WAIT cycle before the count would reach TIMEOUT.
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT - 1);
  assign tmo = ~done & (cnt == TMO_LIM);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      clr_pend <= 1'b0;
      ld_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      ld_q     <= ld_nx;
      wr_q     <= wr_nx;
      cnt      <= (state == ST_WAIT && !done) ? sat_inc(cnt) : '0;
      // A CLR_SC seen while the access is outstanding is deferred to completion.
      clr_pend <= ((state == ST_RUN && any_req) || (state == ST_WAIT && !done))
                  ? (clr_pend | bus.CLR_SC) : 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.START) state_nx = ST_RUN;
      ST_RUN:  if (any_req)   state_nx = ST_WAIT;
      ST_WAIT: begin
        if (done)     state_nx = ST_RUN;
        else if (tmo) state_nx = ST_ERR;
      end
      ST_ERR:  state_nx = ST_ERR;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_nx     = 1'b0;
    wr_nx     = 1'b0;
    ring_hold = 1'b1;
    ring_clr  = 1'b0;
    case (state)
      ST_RUN: begin
        if (any_req) begin
          wr_nx = wr_req;
          ld_nx = rd_req & ~wr_req;
        end else begin
          ring_hold = 1'b0;
          ring_clr  = bus.CLR_SC;
        end
      end
      ST_WAIT: begin
        if (done) begin
          ring_hold = 1'b0;
          ring_clr  = clr_pend | bus.CLR_SC;
        end
      end
      default: ;
    endcase
  end

  sc_ring #(.NUM_T(NUM_T)) u_sc_ring (
    .clk  (CLK),
    .rstn (RSTN),
    .hold (ring_hold),
    .clr  (ring_clr),
    .t    (t)
  );

`ifdef ACCESS_TIMEOUT_EN
  logic err_q;
  always_ff @(posedge CLK) begin
    if (!RSTN)                  err_q <= 1'b0;
    else if (state_nx == ST_ERR) err_q <= 1'b1;
  end
  assign bus.ERR = err_q;
`else
  assign bus.ERR = 1'b0;
`endif

  assign bus.T     = t;
  assign bus.LD    = ld_q;
  assign bus.WR    = wr_q;
  assign bus.BUSY  = (state == ST_WAIT);
  assign bus.state = state;

endmodule

// File: tb/tb_ram_ctrl_seq.sv
// Bench for ram_ctrl_seq: vector table, hand-written corner sequences, random run vs reference model.
module tb_ram_ctrl_seq;

  localparam int W = 12;
`ifdef ACCESS_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;
  localparam int M_ERR  = 3;

  typedef struct {
    bit         st;
    bit         rs;
    logic [7:0] t;
    bit         ld;
    bit         wr;
    bit         busy;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  ram_ctrl_seq_if #(.NUM_T(8), .NUM_OP(8)) bus ();

  ram_ctrl_seq dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase index k, mode, wait count, pending clear
  int m_mode = M_IDLE;
  int m_k    = 0;
  int m_cnt  = 0;
  bit m_pend = 1'b0;
  bit m_ld   = 1'b0;
  bit m_wr   = 1'b0;
  bit m_err  = 1'b0;

  task automatic model_step(input bit st, input bit cl, input logic [7:0] d,
                            input bit i, input bit rdy, input bit rs);
    bit rd;
    bit wr;
    if (!rs) begin
      m_mode = M_IDLE; m_k = 0; m_cnt = 0; m_pend = 0; m_ld = 0; m_wr = 0; m_err = 0;
      return;
    end
    m_ld = 0;
    m_wr = 0;
    case (m_mode)
      M_IDLE: if (st) m_mode = M_RUN;
      M_RUN: begin
        rd = (m_k == 1) || (m_k == 3 && !d[7] && i) || (m_k == 4 && (d & 8'h47) != 0);
        wr = (m_k == 4 && (d & 8'h28) != 0) || (m_k == 6 && (d & 8'h40) != 0);
        if (rd || wr) begin
          m_wr = wr; m_ld = rd && !wr; m_mode = M_WAIT; m_cnt = 0; m_pend = cl;
        end else begin
          m_k = cl ? 0 : (m_k + 1) % 8;
        end
      end
      M_WAIT: begin
        if (rdy && m_cnt >= 1) begin
          m_mode = M_RUN; m_k = (m_pend || cl) ? 0 : (m_k + 1) % 8; m_pend = 0;
        end else if (TMO_ON && m_cnt + 1 >= 15) begin
          m_mode = M_ERR; m_err = 1;
        end else begin
          if (m_cnt < 15) m_cnt++;
          m_pend = m_pend || cl;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [W-1:0] ev(input logic [7:0] t, input bit ld, input bit wr,
                                      input bit busy, input bit err);
    return {t, ld, wr, busy, err};
  endfunction

  function automatic logic [W-1:0] model_out();
    logic [7:0] tv;
    tv = 8'h01 << m_k;
    return ev(tv, m_ld, m_wr, m_mode == M_WAIT, m_err);
  endfunction

  task automatic check(input string name);
    logic [W-1:0] got;
    logic [W-1:0] e;
    got = {bus.T, bus.LD, bus.WR, bus.BUSY, bus.ERR};
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: expected queue empty, got T=%h", name, got[11:4]);
      return;
    end
    e = exp_q.pop_front();
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got T=%h LD=%b WR=%b BUSY=%b ERR=%b, expected T=%h LD=%b WR=%b BUSY=%b ERR=%b",
               name, got[11:4], got[3], got[2], got[1], got[0], e[11:4], e[3], e[2], e[1], e[0]);
    end
  endtask

  // Driver: apply one cycle of inputs, queue expectation, check after the edge
  task automatic drive(input string name, input bit st, input bit cl, input logic [7:0] d,
                       input bit i, input bit rdy, input bit rs,
                       input bit use_model, input logic [W-1:0] e);
    bus.START = st; bus.CLR_SC = cl; bus.D = d; bus.I = i; bus.MEM_RDY = rdy; rstn = rs;
    model_step(st, cl, d, i, rdy, rs);
    exp_q.push_back(use_model ? model_out() : e);
    @(posedge clk);
    #1;
    check(name);
  endtask

  task automatic hv(input string name, input bit st, input bit cl, input logic [7:0] d,
                    input bit i, input bit rdy, input bit rs, input logic [W-1:0] e);
    drive(name, st, cl, d, i, rdy, rs, 1'b0, e);
  endtask

  task automatic mstep(input string name, input bit st, input bit cl, input logic [7:0] d,
                       input bit i, input bit rdy, input bit rs);
    drive(name, st, cl, d, i, rdy, rs, 1'b1, '0);
  endtask

  task automatic advance_to(input int k);
    int n;
    n = 0;
    while (!(m_mode == M_RUN && m_k == k) && n < 40) begin
      mstep("advance", 0, 0, 8'h00, 0, 1, 1);
      n++;
    end
    if (n >= 40) begin
      n_tests++;
      n_fail++;
      $display("FAIL advance_to: T%0d not reached in 40 cycles, model at T%0d", k, m_k);
    end
  endtask

  function automatic vec_t mk(input bit st, input bit rs, input logic [7:0] t,
                              input bit ld, input bit wr, input bit busy);
    vec_t v;
    v.st = st; v.rs = rs; v.t = t; v.ld = ld; v.wr = wr; v.busy = busy;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    bus.START = 0; bus.CLR_SC = 0; bus.D = '0; bus.I = 0; bus.MEM_RDY = 1;

    // Reset, start, T1 read with 2-cycle hold, walk to wrap (START mid-run ignored)
    tbl[0]  = mk(0, 0, 8'h01, 0, 0, 0);
    tbl[1]  = mk(0, 1, 8'h01, 0, 0, 0);
    tbl[2]  = mk(1, 1, 8'h01, 0, 0, 0);
    tbl[3]  = mk(0, 1, 8'h02, 0, 0, 0);
    tbl[4]  = mk(0, 1, 8'h02, 1, 0, 1);
    tbl[5]  = mk(0, 1, 8'h02, 0, 0, 1);
    tbl[6]  = mk(0, 1, 8'h04, 0, 0, 0);
    tbl[7]  = mk(1, 1, 8'h08, 0, 0, 0);
    tbl[8]  = mk(0, 1, 8'h10, 0, 0, 0);
    tbl[9]  = mk(0, 1, 8'h20, 0, 0, 0);
    tbl[10] = mk(0, 1, 8'h40, 0, 0, 0);
    tbl[11] = mk(0, 1, 8'h80, 0, 0, 0);
    tbl[12] = mk(0, 1, 8'h01, 0, 0, 0);
    for (int n = 0; n < 13; n++)
      hv($sformatf("tbl%0d", n), tbl[n].st, 0, 8'h00, 0, 1, tbl[n].rs,
         ev(tbl[n].t, tbl[n].ld, tbl[n].wr, tbl[n].busy, 0));

    // D3 writes at T4
    advance_to(4);
    hv("wr_d3_strobe", 0, 0, 8'h08, 0, 1, 1, ev(8'h10, 0, 1, 1, 0));
    hv("wr_d3_wait",   0, 0, 8'h08, 0, 1, 1, ev(8'h10, 0, 0, 1, 0));
    hv("wr_d3_done",   0, 0, 8'h08, 0, 1, 1, ev(8'h20, 0, 0, 0, 0));

    // D6 reads at T4 and writes at T6
    advance_to(4);
    hv("d6_ld_t4",   0, 0, 8'h40, 0, 1, 1, ev(8'h10, 1, 0, 1, 0));
    hv("d6_wait1",   0, 0, 8'h40, 0, 1, 1, ev(8'h10, 0, 0, 1, 0));
    hv("d6_done1",   0, 0, 8'h40, 0, 1, 1, ev(8'h20, 0, 0, 0, 0));
    hv("d6_t5",      0, 0, 8'h40, 0, 1, 1, ev(8'h40, 0, 0, 0, 0));
    hv("d6_wr_t6",   0, 0, 8'h40, 0, 1, 1, ev(8'h40, 0, 1, 1, 0));
    hv("d6_wait2",   0, 0, 8'h40, 0, 1, 1, ev(8'h40, 0, 0, 1, 0));
    hv("d6_done2",   0, 0, 8'h40, 0, 1, 1, ev(8'h80, 0, 0, 0, 0));

    // Indirect read at T3, suppressed for D7
    advance_to(3);
    hv("ind_ld",     0, 0, 8'h00, 1, 1, 1, ev(8'h08, 1, 0, 1, 0));
    hv("ind_wait",   0, 0, 8'h00, 1, 1, 1, ev(8'h08, 0, 0, 1, 0));
    hv("ind_done",   0, 0, 8'h00, 1, 1, 1, ev(8'h10, 0, 0, 0, 0));
    advance_to(3);
    hv("ind_d7_none", 0, 0, 8'h80, 1, 1, 1, ev(8'h10, 0, 0, 0, 0));

    // Early MEM_RDY ignored, CLR_SC deferred until completion
    advance_to(3);
    hv("pend_ld",     0, 0, 8'h00, 1, 0, 1, ev(8'h08, 1, 0, 1, 0));
    hv("pend_early",  0, 0, 8'h00, 0, 1, 1, ev(8'h08, 0, 0, 1, 0));
    hv("pend_clr",    0, 1, 8'h00, 0, 0, 1, ev(8'h08, 0, 0, 1, 0));
    hv("pend_hold1",  0, 0, 8'h00, 0, 0, 1, ev(8'h08, 0, 0, 1, 0));
    hv("pend_hold2",  0, 0, 8'h00, 0, 0, 1, ev(8'h08, 0, 0, 1, 0));
    hv("pend_to_t0",  0, 0, 8'h00, 0, 1, 1, ev(8'h01, 0, 0, 0, 0));
    hv("pend_clear",  0, 0, 8'h00, 0, 1, 1, ev(8'h02, 0, 0, 0, 0));

    // Reset in the middle of an access
    hv("rst_ld",      0, 0, 8'h00, 0, 0, 1, ev(8'h02, 1, 0, 1, 0));
    hv("rst_wait",    0, 0, 8'h00, 0, 0, 1, ev(8'h02, 0, 0, 1, 0));
    hv("rst_mid",     0, 0, 8'h00, 0, 0, 0, ev(8'h01, 0, 0, 0, 0));
    hv("rst_idle",    0, 0, 8'h00, 0, 1, 1, ev(8'h01, 0, 0, 0, 0));
    hv("idle_clr",    0, 1, 8'h00, 0, 1, 1, ev(8'h01, 0, 0, 0, 0));
    hv("restart",     1, 0, 8'h00, 0, 1, 1, ev(8'h01, 0, 0, 0, 0));
    hv("restart_t1",  0, 0, 8'h00, 0, 1, 1, ev(8'h02, 0, 0, 0, 0));

    // Memory never answers
    hv("tmo_ld",      0, 0, 8'h00, 0, 0, 1, ev(8'h02, 1, 0, 1, 0));
    for (int n = 0; n < 14; n++)
      hv($sformatf("tmo_wait%0d", n), 0, 0, 8'h00, 0, 0, 1, ev(8'h02, 0, 0, 1, 0));
`ifdef ACCESS_TIMEOUT_EN
    hv("tmo_err",     0, 0, 8'h00, 0, 0, 1, ev(8'h02, 0, 0, 0, 1));
    hv("tmo_frozen",  0, 0, 8'h00, 0, 1, 1, ev(8'h02, 0, 0, 0, 1));
`else
    hv("tmo_no_err",  0, 0, 8'h00, 0, 0, 1, ev(8'h02, 0, 0, 1, 0));
    hv("tmo_late_rdy", 0, 0, 8'h00, 0, 1, 1, ev(8'h04, 0, 0, 0, 0));
`endif
    hv("tmo_reset",   0, 0, 8'h00, 0, 1, 0, ev(8'h01, 0, 0, 0, 0));

    // Random traffic against the reference model
    mstep("rnd_start", 1, 0, 8'h00, 0, 1, 1);
    for (int n = 0; n < 800; n++) begin
      int sel;
      logic [7:0] d;
      sel = $urandom_range(0, 8);
      d = (sel == 8) ? 8'h00 : (8'h01 << sel);
      mstep($sformatf("rnd%0d", n),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0,
            d,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 63) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
